// File: rtl/top_defs.sv
// Shared definitions for the in_debounce input stage.
// Holds the debounce FSM state encodings.
package top_defs;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

endpackage

// File: rtl/in_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the CLK domain.
// Both stages clear on synchronous reset.
module in_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic sync0;

    // shift the raw level through two flops
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync0 <= 1'b0;
            Q     <= 1'b0;
        end else begin
            sync0 <= D;
            Q     <= sync0;
        end
    end

endmodule

// File: rtl/in_debounce.sv
// Input conditioning stage: synchronize, debounce, and report level edges.
// Provides a clean level, one-cycle edge pulses and a saturating rise counter.
module in_debounce
    import top_defs::*;
#(
    parameter int STABLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_RAW,
    input  logic             CLR,
    output logic             OUT,
    output logic             RISE,
    output logic             FALL,
    output logic [CNT_W-1:0] EVT_CNT
);

    localparam int DBC_W = $clog2(STABLE) + 1;
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1;
    state_t           state;
    logic [DBC_W-1:0] dbc;

    in_sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (IN_RAW),
        .Q   (sync1)
    );

    // debounce FSM: a new level must be seen STABLE times in a row
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_LOW;
            dbc   <= '0;
            OUT   <= 1'b0;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
        end else begin
            RISE <= 1'b0;
            FALL <= 1'b0;
            unique case (state)
                S_LOW: begin
                    if (sync1) begin
                        state <= S_RISE_CHK;
                        dbc   <= DBC_W'(1);
                    end else begin
                        dbc <= '0;
                    end
                end
                S_RISE_CHK: begin
                    if (!sync1) begin
                        state <= S_LOW;
                        dbc   <= '0;
                    end else if (dbc == DBC_LAST) begin
                        state <= S_HIGH;
                        dbc   <= '0;
                        OUT   <= 1'b1;
                        RISE  <= 1'b1;
                    end else begin
                        dbc <= dbc + DBC_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!sync1) begin
                        state <= S_FALL_CHK;
                        dbc   <= DBC_W'(1);
                    end else begin
                        dbc <= '0;
                    end
                end
                S_FALL_CHK: begin
                    if (sync1) begin
                        state <= S_HIGH;
                        dbc   <= '0;
                    end else if (dbc == DBC_LAST) begin
                        state <= S_LOW;
                        dbc   <= '0;
                        OUT   <= 1'b0;
                        FALL  <= 1'b1;
                    end else begin
                        dbc <= dbc + DBC_W'(1);
                    end
                end
            endcase
        end
    end

    // count cycles with RISE high; a clear in such a cycle keeps that event
    always_ff @(posedge CLK) begin
        if (RST) begin
            EVT_CNT <= '0;
        end else if (CLR) begin
            EVT_CNT <= RISE ? CNT_W'(1) : '0;
        end else if (RISE && EVT_CNT != CNT_MAX) begin
            EVT_CNT <= EVT_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_in_debounce.sv
// Testbench for in_debounce: per-cycle vector table plus directed
// sequences for mid-debounce reset and counter saturation/clear.
module tb_in_debounce;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_RAW = 1'b0;
    logic       CLR = 1'b0;
    logic       OUT, RISE, FALL;
    logic [7:0] EVT_CNT;

    logic       raw2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       out2, rise2, fall2;
    logic [1:0] cnt2;

    int total = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    in_debounce #(.STABLE(4), .CNT_W(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .IN_RAW  (IN_RAW),
        .CLR     (CLR),
        .OUT     (OUT),
        .RISE    (RISE),
        .FALL    (FALL),
        .EVT_CNT (EVT_CNT)
    );

    in_debounce #(.STABLE(4), .CNT_W(2)) dut2 (
        .CLK     (CLK),
        .RST     (RST),
        .IN_RAW  (raw2),
        .CLR     (clr2),
        .OUT     (out2),
        .RISE    (rise2),
        .FALL    (fall2),
        .EVT_CNT (cnt2)
    );

    typedef struct {
        logic       rst;
        logic       raw;
        logic       clr;
        logic       out;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic raw,
                       input logic clr, input logic out, input logic rise,
                       input logic fall, input logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.raw = raw; v.clr = clr;
        v.out = out; v.rise = rise; v.fall = fall; v.cnt = cnt;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n;
        bit found;

        // T1: reset with raw high, then release with raw low
        add(3, 1, 1, 0, 0, 0, 0, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0);
        // T2: raw rises; OUT on the 6th edge counting the first sampling edge
        add(5, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1, 0, 0);
        add(2, 0, 1, 0, 1, 0, 0, 1);
        // T4: raw falls
        add(5, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1, 1);
        add(2, 0, 0, 0, 0, 0, 0, 1);
        // T3: 3-cycle glitch rejected
        add(3, 0, 1, 0, 0, 0, 0, 1);
        add(6, 0, 0, 0, 0, 0, 0, 1);
        // exactly STABLE cycles high is accepted, then falls again
        add(4, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1, 0, 1);
        add(3, 0, 0, 0, 1, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 0, 2);
        // CLR alone clears the counter
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            RST = vecs[i].rst;
            IN_RAW = vecs[i].raw;
            CLR = vecs[i].clr;
            step();
            check($sformatf("v%0d_out", i), int'(OUT), int'(vecs[i].out));
            check($sformatf("v%0d_rise", i), int'(RISE), int'(vecs[i].rise));
            check($sformatf("v%0d_fall", i), int'(FALL), int'(vecs[i].fall));
            check($sformatf("v%0d_cnt", i), int'(EVT_CNT), int'(vecs[i].cnt));
        end

        // T6: reset during S_RISE_CHK with dbc=2
        IN_RAW = 1'b1;
        repeat (4) step();
        check("t6_state_pre", int'(dut.state), 1);
        check("t6_dbc_pre", int'(dut.dbc), 2);
        RST = 1'b1;
        step();
        check("t6_state_rst", int'(dut.state), 0);
        check("t6_dbc_rst", int'(dut.dbc), 0);
        check("t6_out_rst", int'(OUT), 0);
        check("t6_rise_rst", int'(RISE), 0);
        RST = 1'b0;
        n = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            n++;
            if (OUT) found = 1;
        end
        check("t6_found", int'(found), 1);
        check("t6_latency", n, 6);
        check("t6_rise", int'(RISE), 1);
        step();
        check("t6_cnt", int'(EVT_CNT), 1);
        IN_RAW = 1'b0;
        repeat (8) step();
        check("t6_out_low", int'(OUT), 0);

        // T5: 2-bit counter saturates at 3
        for (int i = 1; i <= 5; i++) begin
            raw2 = 1'b1;
            repeat (8) step();
            raw2 = 1'b0;
            repeat (8) step();
            check($sformatf("t5_cnt_%0d", i), int'(cnt2), (i < 3) ? i : 3);
        end
        raw2 = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (rise2) found = 1;
        end
        check("t5_rise_seen", int'(found), 1);
        check("t5_cnt_sat", int'(cnt2), 3);
        clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        check("t5_clr_rise", int'(cnt2), 1);
        check("t5_out2", int'(out2), 1);
        check("t5_no_fall", int'(fall2), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
